// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver.
// - Synchronises and glitch-filters the keyboard clock and data lines.
// - Deframes 11-bit frames: start, 8 data bits LSB first, odd parity, stop.
// - Decodes make codes and F0 break codes into the last-pressed scan code
//   plus a key-held flag.
// Output handshake: o_byte_valid is a single-cycle pulse with no ready
// (the sink must always accept). o_ps2_byte and o_ps2_state are valid on
// the same cycle as the pulse and hold until the next decoded frame.
// o_parity_err is a single-cycle pulse, and nothing else changes with it.
module ps2_kbd_rx #(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_ps2_byte,
  output logic       o_ps2_state,
  output logic       o_byte_valid,
  output logic       o_parity_err,
  output logic [1:0] o_dbg_state,
  output logic [1:0] o_dbg_flags
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int WW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_clk_s1;
  logic            r_clk_s2;
  logic            r_dat_s1;
  logic            r_dat_s2;
  logic            r_clk_filt;
  logic [FW-1:0]   r_filt_cnt;
  logic [WW-1:0]   r_wd_cnt;
  logic [7:0]      r_sh;
  logic            r_par;
  logic [2:0]      r_bit_cnt;
  logic            r_brk;
  logic            r_ext;
  logic [7:0]      r_byte;
  logic            r_key_held;
  logic            r_byte_valid;
  logic            r_parity_err;
  logic            w_filt_flip;
  logic            w_fall;
  logic            w_wd_exp;
  logic            w_good;
  logic            w_frame_ok;
  logic            w_frame_bad;

  // Two-flop synchronisers on both pad inputs; idle level is high.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= i_ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // The filtered clock follows the synchronised clock only after FILT_LEN
  // consecutive samples disagree with it; any agreeing sample restarts the count.
  assign w_filt_flip = (r_clk_s2 != r_clk_filt) && (r_filt_cnt == FW'(FILT_LEN - 1));
  assign w_fall      = w_filt_flip && r_clk_filt;

  // Glitch filter counter and filtered clock level.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
    end else if (r_clk_s2 == r_clk_filt) begin
      r_filt_cnt <= '0;
    end else if (w_filt_flip) begin
      r_clk_filt <= r_clk_s2;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + FW'(1);
    end
  end

  // A fall always wins over expiry, so a completing frame is never aborted.
  assign w_wd_exp = (r_state != S_IDLE) && !w_fall &&
                    (r_wd_cnt == WW'(TIMEOUT_CYC - 1));

  // Watchdog: counts idle system clocks while a frame is in progress.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wd_cnt <= '0;
    end else if (w_fall || r_state == S_IDLE || w_wd_exp) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + WW'(1);
    end
  end

  // Odd parity over the data byte and the received parity bit, plus the stop bit.
  assign w_good      = r_dat_s2 && (^{r_sh, r_par});
  assign w_frame_ok  = w_fall && (r_state == S_STOP) && w_good;
  assign w_frame_bad = w_fall && (r_state == S_STOP) && !w_good;

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state: advances on filtered falls; watchdog expiry forces IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_fall && !r_dat_s2) w_next = S_DATA;
      S_DATA:   if (w_fall && r_bit_cnt == 3'd7) w_next = S_PARITY;
      S_PARITY: if (w_fall) w_next = S_STOP;
      S_STOP:   if (w_fall) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_wd_exp) w_next = S_IDLE;
  end

  // Frame capture: shift data bits in LSB first and hold the parity bit.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sh      <= '0;
      r_par     <= 1'b0;
      r_bit_cnt <= '0;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE:   r_bit_cnt <= '0;
        S_DATA: begin
          r_sh      <= {r_dat_s2, r_sh[7:1]};
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        S_PARITY: r_par <= r_dat_s2;
        default:  r_bit_cnt <= '0;
      endcase
    end
  end

  // Make/break decode of each good frame; pulses are cleared every cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_brk        <= 1'b0;
      r_ext        <= 1'b0;
      r_byte       <= '0;
      r_key_held   <= 1'b0;
      r_byte_valid <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_parity_err <= w_frame_bad;
      if (w_frame_ok) begin
        if (r_sh == 8'hF0) begin
          r_brk <= 1'b1;
        end else if (r_sh == 8'hE0) begin
          r_ext <= 1'b1;
        end else if (r_brk) begin
          r_brk <= 1'b0;
          r_ext <= 1'b0;
          if (r_sh == r_byte) r_key_held <= 1'b0;
        end else begin
          r_byte       <= r_sh;
          r_key_held   <= 1'b1;
          r_byte_valid <= 1'b1;
          r_ext        <= 1'b0;
        end
      end
    end
  end

  assign o_ps2_byte   = r_byte;
  assign o_ps2_state  = r_key_held;
  assign o_byte_valid = r_byte_valid;
  assign o_parity_err = r_parity_err;
  assign o_dbg_state  = r_state;
  assign o_dbg_flags  = {r_brk, r_ext};

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: directed PS/2 frames with a queue-based scoreboard.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

  localparam int FILT_LEN    = 8;
  localparam int TIMEOUT_CYC = 1000;
  localparam int HALF        = 40;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] ps2_byte;
  logic       ps2_state;
  logic       byte_valid;
  logic       parity_err;
  logic [1:0] dbg_state;
  logic [1:0] dbg_flags;

  ps2_kbd_rx #(.FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_data   (ps2_data),
    .o_ps2_byte   (ps2_byte),
    .o_ps2_state  (ps2_state),
    .o_byte_valid (byte_valid),
    .o_parity_err (parity_err),
    .o_dbg_state  (dbg_state),
    .o_dbg_flags  (dbg_flags)
  );

  // ---------------- scoreboard ----------------
  // Entry: [9] 1 = byte_valid event, 0 = parity_err event; [8] key held; [7:0] byte.
  logic [9:0] exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] m_byte;
  logic       m_state;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (byte_valid === 1'b1 || parity_err === 1'b1)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pulse: got valid=%0b perr=%0b expected no pulse at %0t",
                 byte_valid, parity_err, $time);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("event_kind", {30'd0, byte_valid, parity_err}, e[9] ? 32'd2 : 32'd1);
        check("event_byte", {24'd0, ps2_byte}, {24'd0, e[7:0]});
        check("event_state", {31'd0, ps2_state}, {31'd0, e[8]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(~bad_stop);
    ps2_data = 1'b1;
    tick(100);
  endtask

  task automatic expect_make(input logic [7:0] b);
    m_byte  = b;
    m_state = 1'b1;
    exp_q.push_back({1'b1, 1'b1, b});
  endtask

  task automatic expect_perr();
    exp_q.push_back({1'b0, m_state, m_byte});
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_byte"}, {24'd0, ps2_byte}, {24'd0, m_byte});
    check({tag, "_state"}, {31'd0, ps2_state}, {31'd0, m_state});
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #3_000_000;
    $display("FAIL time_limit: got no finish expected finish before 3 ms");
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    m_byte   = 8'h00;
    m_state  = 1'b0;
    tick(5);
    check("rst_byte", {24'd0, ps2_byte}, 32'd0);
    check("rst_state", {31'd0, ps2_state}, 32'd0);
    check("rst_valid", {31'd0, byte_valid}, 32'd0);
    check("rst_perr", {31'd0, parity_err}, 32'd0);
    check("rst_fsm", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    tick(10);

    // 1: plain make code
    expect_make(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b0);
    check_outputs("t1");

    // 2: break of the held key releases it
    send_frame(8'hF0, 1'b0, 1'b0);
    check("t2_brk_flag", {30'd0, dbg_flags}, 32'd2);
    send_frame(8'h1C, 1'b0, 1'b0);
    m_state = 1'b0;
    check_outputs("t2_release");
    check("t2_flags_clear", {30'd0, dbg_flags}, 32'd0);
    // press again, then a typematic repeat of the same code
    expect_make(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b0);
    expect_make(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b0);
    check_outputs("t2_repeat");
    // break of a different key leaves the held flag alone
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1B, 1'b0, 1'b0);
    check_outputs("t2_other_break");

    // 3: bad parity, then bad stop bit
    expect_perr();
    send_frame(8'h32, 1'b1, 1'b0);
    check_outputs("t3_parity");
    expect_perr();
    send_frame(8'h32, 1'b0, 1'b1);
    check_outputs("t3_stop");

    // extended prefix followed by a make code
    send_frame(8'hE0, 1'b0, 1'b0);
    check("ext_flag", {30'd0, dbg_flags}, 32'd1);
    expect_make(8'h75);
    send_frame(8'h75, 1'b0, 1'b0);
    check_outputs("ext_make");

    // 4: short glitch on the clock line is ignored
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    tick(5);
    ps2_clk  = 1'b1;
    tick(30);
    ps2_data = 1'b1;
    tick(20);
    check("t4_fsm_idle", {30'd0, dbg_state}, 32'd0);
    expect_make(8'h24);
    send_frame(8'h24, 1'b0, 1'b0);
    check_outputs("t4");

    // 5: partial frame then stall; watchdog aborts silently
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    ps2_data = 1'b1;
    check("t5_fsm_busy", {30'd0, dbg_state}, 32'd1);
    tick(1500);
    check("t5_fsm_idle", {30'd0, dbg_state}, 32'd0);
    check_outputs("t5_stall");
    expect_make(8'h24);
    send_frame(8'h24, 1'b0, 1'b0);
    check_outputs("t5");

    // 6: reset in the middle of a frame
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    rst_n = 1'b0;
    tick(2);
    m_byte  = 8'h00;
    m_state = 1'b0;
    check_outputs("t6_reset");
    check("t6_fsm", {30'd0, dbg_state}, 32'd0);
    rst_n    = 1'b1;
    ps2_data = 1'b1;
    tick(20);
    expect_make(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b0);
    check_outputs("t6");

    // all expected pulses must have been seen
    check("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
